jt51_kon_sched: RTL and testbench
=================================

JT51_KON_SCHED -- requirements
Module: jt51_kon_sched

Interface
REQ-001 Parameter: RST_DLY, default 2, number of cen-qualified stages from stage I to pg_rst_III; range 1..4.
REQ-002 clk  input  1  system clock; all flops on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low. Assertion clears all state immediately; release is synchronous to clk.
REQ-004 cen  input  1  clock enable; the slot counter, FSM transitions and output pipeline advance only when cen=1.
REQ-005 kon_we  input  1  key-on register write strobe; sampled on every clk edge, independent of cen.
REQ-006 kon_ch  input  3  target channel 0..7; valid with kon_we.
REQ-007 kon_op  input  4  operator key-on mask: bit0=M1, bit1=C1, bit2=M2, bit3=C2.
REQ-008 busy  output  1  high while a write is pending or being applied.
REQ-009 kon_ovf  output  1  one-clk pulse when a write is rejected.
REQ-010 zero  output  1  high while slot_I==0.
REQ-011 slot_I  output  5  current operator slot: {op[1:0], ch[2:0]}, with op 0=M1, 1=M2, 2=C1, 3=C2.
REQ-012 kon_I  output  1  key-on state of the operator in slot_I.
REQ-013 pg_rst_III  output  1  phase-reset pulse for the phase generator, RST_DLY cen-stages after the matching slot_I.

Function
REQ-014 The 5-bit counter cnt SHALL increment by 1 on each cen and wrap from 31 to 0; slot_I SHALL be a registered copy of cnt.
REQ-015 zero SHALL be registered and high exactly during the cycles when slot_I==0.
REQ-016 A 32-bit register kon_state SHALL hold one key-on bit per slot.
REQ-017 The FSM SHALL have three states: IDLE, WAIT, APPLY; busy SHALL be 1 in WAIT and APPLY.
REQ-018 IDLE with kon_we=1: latch kon_ch and kon_op into pend_ch and pend_op, go to WAIT. This happens on that clk edge regardless of cen.
REQ-019 WAIT to APPLY: on the cen edge where cnt==31. A write accepted in the same clk as cnt==31 SHALL still wait a full revolution.
REQ-020 In APPLY, on each cen, for the slot s=cnt: if s[2:0]==pend_ch, kon_state[s] <= the pend_op bit mapped by s[4:3] (M1 to bit0, M2 to bit2, C1 to bit1, C2 to bit3). Otherwise kon_state[s] is unchanged.
REQ-021 APPLY to IDLE: on the cen edge that processes cnt==31; busy SHALL be 0 in the following clk.
REQ-022 kon_we=1 while busy: the write is ignored, pending data is unchanged, and kon_ovf SHALL pulse high for exactly one clk.
REQ-023 kon_I SHALL be registered alongside slot_I and carry the post-update value of kon_state[cnt].
REQ-024 pg_rst_I SHALL be 1 when kon_state[cnt] goes 0 to 1 in that cen; it SHALL be 0 for 1 to 1, 1 to 0, or no update.
REQ-025 pg_rst_I SHALL be delayed through RST_DLY cen-qualified registers to form pg_rst_III, aligned to slot_I plus RST_DLY slots.
REQ-026 With cen=0, all cen-qualified registers SHALL hold their values; only the REQ-018 acceptance and kon_ovf may change.

Reset
REQ-027 While rst_n=0: cnt=0, slot_I=0, zero=1, kon_state=0, kon_I=0, pend_ch=0, pend_op=0, FSM=IDLE, busy=0, kon_ovf=0, and the pg_rst pipeline=0.
REQ-028 Reset asserted during WAIT or APPLY SHALL discard the pending write; after release no partial update resumes.

Verification
REQ-029 Free-run with cen=1 for 64 clks: slot_I sequences 0..31 twice; zero is high at slot_I=0 only; busy=0, kon_I=0, pg_rst_III=0 throughout.
REQ-030 Key-on, cen=1: write kon_ch=2, kon_op=4'b0001 with cnt=5 -> busy=1. APPLY starts at cnt=0 after the next wrap. kon_I=1 and pg_rst_I=1 at slot_I=2, pg_rst_III=1 exactly 2 cens later, busy=0 after slot 31.
REQ-031 Repeat the same write: kon_state is unchanged and pg_rst_III stays 0. Then write kon_ch=2, kon_op=0: kon_I at slot 2 becomes 0 and no pg_rst.
REQ-032 Full mask: write kon_ch=7, kon_op=4'hF -> pg_rst_III pulses for slots 7, 15, 23, 31 only; no other slot changes.
REQ-033 Overflow: second write during WAIT -> kon_ovf high one clk; the first write is applied and the second is not.
REQ-034 Boundary cases:
  - cen toggling 1 of 3 clks: slot timing scales and acceptance still works.
  - rst_n pulsed low mid-APPLY: all REQ-027 values are restored asynchronously.

Source files
------------

// File: rtl/jt51_kon_sched_if.sv
// jt51_kon_sched_if
//   Bundles the key-on write port and the slot-timing outputs of
//   jt51_kon_sched.
//   master : register-write side. It drives kon_we/kon_ch/kon_op and observes
//            the scheduler outputs.
//   slave  : the scheduler itself.
//   Signals:
//     kon_we, kon_ch[2:0], kon_op[3:0]  key-on write strobe, channel and
//                                       operator mask
//     busy, kon_ovf                     write pending / write rejected pulse
//     zero, slot_I[4:0], kon_I          stage-I slot timing and key-on state
//     pg_rst_III                        delayed phase-reset pulse
interface jt51_kon_sched_if;
   logic       kon_we;
   logic [2:0] kon_ch;
   logic [3:0] kon_op;
   logic       busy;
   logic       kon_ovf;
   logic       zero;
   logic [4:0] slot_I;
   logic       kon_I;
   logic       pg_rst_III;

   modport master (
      output kon_we, kon_ch, kon_op,
      input  busy, kon_ovf, zero, slot_I, kon_I, pg_rst_III
   );

   modport slave (
      input  kon_we, kon_ch, kon_op,
      output busy, kon_ovf, zero, slot_I, kon_I, pg_rst_III
   );
endinterface

// File: rtl/jt51_kon_sched.sv
// jt51_kon_sched
//   Key-on scheduler for a 32-slot (8 channels x 4 operators) FM engine.
//   A write to the key-on register is first parked. It is then applied to the
//   per-slot key-on bits during one full revolution of the slot counter, and
//   that revolution always starts at slot 0. A 0->1 key-on transition raises
//   a phase-reset pulse that is delayed to line up with the phase generator.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     cen    clock enable for the slot counter, FSM and output pipeline
//     bus    jt51_kon_sched_if.slave (write port and slot outputs)
//   Parameter:
//     RST_DLY  cen stages from stage I to pg_rst_III (1..4)
module jt51_kon_sched #(
   parameter int RST_DLY = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cen,
   jt51_kon_sched_if.slave        bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_APPLY} state_t;

   state_t             state_q,     state_d;
   logic [4:0]         cnt_q,       cnt_d;
   logic [4:0]         slot_q,      slot_d;
   logic               zero_q,      zero_d;
   logic [31:0]        kon_state_q, kon_state_d;
   logic               kon_q,       kon_d;
   logic [2:0]         pend_ch_q,   pend_ch_d;
   logic [3:0]         pend_op_q,   pend_op_d;
   logic               ovf_q,       ovf_d;
   logic               pg_rst_I_q,  pg_rst_I_d;
   logic [RST_DLY-1:0] pg_dly_q,    pg_dly_d;

   logic busy;
   logic cur_bit;
   logic new_bit;
   logic apply_hit;

   always_comb begin
      // NOTE: every variable gets its hold value first, so no path through
      // the branches below can leave one unassigned and infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      slot_d      = slot_q;
      zero_d      = zero_q;
      kon_state_d = kon_state_q;
      kon_d       = kon_q;
      pend_ch_d   = pend_ch_q;
      pend_op_d   = pend_op_q;
      pg_rst_I_d  = pg_rst_I_q;
      pg_dly_d    = pg_dly_q;

      busy    = (state_q != ST_IDLE);
      cur_bit = kon_state_q[cnt_q];
      // The slot operator order is M1,M2,C1,C2 and the mask order is
      // M1,C1,M2,C2. Swapping the two operator bits maps one to the other.
      new_bit   = pend_op_q[{cnt_q[3], cnt_q[4]}];
      apply_hit = (state_q == ST_APPLY) && (cnt_q[2:0] == pend_ch_q);

      // A write is rejected whenever one is already in flight. This is
      // sampled on every clk, not only on cen.
      ovf_d = bus.kon_we & busy;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.kon_we) begin
               pend_ch_d = bus.kon_ch;
               pend_op_d = bus.kon_op;
               state_d   = ST_WAIT;
            end
         end
         // Leave WAIT only at the end of a revolution. Applying then covers
         // slots 0..31 in order, even for a write that arrived at slot 31.
         ST_WAIT:  if (cen && cnt_q == 5'd31) state_d = ST_APPLY;
         ST_APPLY: if (cen && cnt_q == 5'd31) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (cen) begin
         cnt_d      = cnt_q + 5'd1;
         slot_d     = cnt_q;
         zero_d     = (cnt_q == 5'd0);
         kon_d      = cur_bit;
         pg_rst_I_d = 1'b0;
         if (apply_hit) begin
            kon_state_d[cnt_q] = new_bit;
            kon_d              = new_bit;
            pg_rst_I_d         = new_bit & ~cur_bit;
         end
         pg_dly_d[0] = pg_rst_I_q;
         for (int i = 1; i < RST_DLY; i++) pg_dly_d[i] = pg_dly_q[i-1];
      end
   end

   // The key-on bits live in flops rather than a RAM, so they clear with the
   // rest of the state and a reset can never leave a half-applied write.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments let every flop sample the old values
      // at the same edge, whatever the statement order.
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 5'd0;
         slot_q      <= 5'd0;
         zero_q      <= 1'b1;
         kon_state_q <= 32'd0;
         kon_q       <= 1'b0;
         pend_ch_q   <= 3'd0;
         pend_op_q   <= 4'd0;
         ovf_q       <= 1'b0;
         pg_rst_I_q  <= 1'b0;
         pg_dly_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         slot_q      <= slot_d;
         zero_q      <= zero_d;
         kon_state_q <= kon_state_d;
         kon_q       <= kon_d;
         pend_ch_q   <= pend_ch_d;
         pend_op_q   <= pend_op_d;
         ovf_q       <= ovf_d;
         pg_rst_I_q  <= pg_rst_I_d;
         pg_dly_q    <= pg_dly_d;
      end
   end

   assign bus.busy       = busy;
   assign bus.kon_ovf    = ovf_q;
   assign bus.zero       = zero_q;
   assign bus.slot_I     = slot_q;
   assign bus.kon_I      = kon_q;
   assign bus.pg_rst_III = pg_dly_q[RST_DLY-1];

endmodule

// File: tb/tb_jt51_kon_sched.sv
// tb_jt51_kon_sched
//   Directed bench for jt51_kon_sched with RST_DLY=2. Outputs are sampled on
//   the falling clock edge. Each write is followed through its apply
//   revolution. The phase-reset pulses and the resulting key-on bits are
//   compared against hand-computed 32-bit slot masks.
module tb_jt51_kon_sched;
   localparam int DLY = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic cen;

   jt51_kon_sched_if bus ();

   jt51_kon_sched #(.RST_DLY(DLY)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cen   (cen),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int period   = 1;   // cen is high on 1 clk out of every `period`
   int phase    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Set cen for the coming rising edge, then return at the following falling
   // edge so that outputs can be sampled.
   task automatic tick();
      cen   = (phase == 0);
      phase = (phase + 1) % period;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_write(input logic [2:0] ch, input logic [3:0] op);
      bus.kon_we = 1'b1;
      bus.kon_ch = ch;
      bus.kon_op = op;
      tick();
      bus.kon_we = 1'b0;
      bus.kon_ch = 3'd0;
      bus.kon_op = 4'd0;
   endtask

   task automatic wait_slot(input string tag, input logic [4:0] target);
      int k = 0;
      while (bus.slot_I !== target && k < 400) begin
         tick();
         k++;
      end
      check({tag, " wait_slot"}, bus.slot_I, target);
   endtask

   // Follow a pending write to completion. Collect the slots whose phase
   // reset fired, then read back the key-on bit of every slot during one
   // idle revolution.
   task automatic run_apply(input string tag, input logic [31:0] exp_pg, input logic [31:0] exp_kon);
      logic [31:0] obs_pg  = 32'd0;
      logic [31:0] obs_kon = 32'd0;
      logic        seen_pg = 1'b0;
      logic        seen_busy = 1'b0;
      logic [4:0]  s;
      int k = 0;
      while (bus.busy === 1'b1 && k < 400) begin
         tick();
         k++;
         if (bus.pg_rst_III) begin
            s = bus.slot_I - 5'(DLY);
            obs_pg[s] = 1'b1;
         end
      end
      check({tag, " busy"}, bus.busy, 1'b0);
      check({tag, " busy drop slot"}, bus.slot_I, 5'd31);
      for (int i = 0; i < 3 * period; i++) begin
         tick();
         if (bus.pg_rst_III) begin
            s = bus.slot_I - 5'(DLY);
            obs_pg[s] = 1'b1;
         end
      end
      check({tag, " pg slots"}, obs_pg, exp_pg);
      for (int i = 0; i < 32 * period; i++) begin
         tick();
         obs_kon[bus.slot_I] = bus.kon_I;
         seen_pg   |= bus.pg_rst_III;
         seen_busy |= bus.busy;
      end
      check({tag, " kon slots"}, obs_kon, exp_kon);
      check({tag, " idle pg"}, seen_pg, 1'b0);
      check({tag, " idle busy"}, seen_busy, 1'b0);
   endtask

   initial begin
      logic [31:0] obs_kon;
      logic        seen_pg;
      logic        seen_busy;
      logic        seen_bad;
      logic [4:0]  exp_slot;

      rst_n      = 1'b0;
      cen        = 1'b1;
      bus.kon_we = 1'b0;
      bus.kon_ch = 3'd0;
      bus.kon_op = 4'd0;

      // Reset state, with the clock running and cen high.
      repeat (3) @(negedge clk);
      check("rst slot_I", bus.slot_I, 5'd0);
      check("rst zero", bus.zero, 1'b1);
      check("rst busy", bus.busy, 1'b0);
      check("rst kon_ovf", bus.kon_ovf, 1'b0);
      check("rst kon_I", bus.kon_I, 1'b0);
      check("rst pg_rst_III", bus.pg_rst_III, 1'b0);
      rst_n = 1'b1;

      // Free run: slot_I goes 0..31 twice, and zero follows slot 0.
      seen_bad = 1'b0;
      for (int k = 1; k <= 64; k++) begin
         tick();
         exp_slot = 5'((k - 1) % 32);
         check("free slot_I", bus.slot_I, exp_slot);
         check("free zero", bus.zero, exp_slot == 5'd0);
         seen_bad |= bus.busy | bus.kon_I | bus.pg_rst_III | bus.kon_ovf;
      end
      check("free quiet outputs", seen_bad, 1'b0);

      // Key-on of channel 2 M1, written while cnt==5 (slot_I==4).
      wait_slot("kon", 5'd4);
      do_write(3'd2, 4'b0001);
      check("kon busy", bus.busy, 1'b1);
      check("kon no ovf", bus.kon_ovf, 1'b0);
      run_apply("kon", 32'h0000_0004, 32'h0000_0004);

      // The same write again is not a new key-on. Then key-off.
      do_write(3'd2, 4'b0001);
      run_apply("rekon", 32'h0000_0000, 32'h0000_0004);
      do_write(3'd2, 4'b0000);
      run_apply("koff", 32'h0000_0000, 32'h0000_0000);

      // Full mask on channel 7 touches slots 7, 15, 23 and 31 only.
      do_write(3'd7, 4'hF);
      run_apply("full", 32'h8080_8080, 32'h8080_8080);

      // Overflow: the second write is rejected and only the first applies.
      wait_slot("ovf", 5'd3);
      do_write(3'd1, 4'b0010);
      check("ovf first no ovf", bus.kon_ovf, 1'b0);
      do_write(3'd3, 4'hF);
      check("ovf pulse", bus.kon_ovf, 1'b1);
      tick();
      check("ovf pulse end", bus.kon_ovf, 1'b0);
      run_apply("ovf", 32'h0002_0000, 32'h8082_8080);

      // cen high on 1 clk in 3. The write lands on a clk with cen low.
      period = 3;
      phase  = 0;
      tick();
      do_write(3'd0, 4'b1000);
      check("cen3 accept", bus.busy, 1'b1);
      run_apply("cen3", 32'h0100_0000, 32'h8182_8080);
      period = 1;
      phase  = 0;

      // Reset in the middle of APPLY, after slot 5 has been keyed on.
      wait_slot("mid", 5'd10);
      do_write(3'd5, 4'hF);
      wait_slot("mid apply", 5'd31);
      repeat (10) tick();
      check("mid busy before rst", bus.busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mid rst slot_I", bus.slot_I, 5'd0);
      check("mid rst zero", bus.zero, 1'b1);
      check("mid rst busy", bus.busy, 1'b0);
      check("mid rst kon_ovf", bus.kon_ovf, 1'b0);
      check("mid rst kon_I", bus.kon_I, 1'b0);
      check("mid rst pg_rst_III", bus.pg_rst_III, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      obs_kon   = 32'd0;
      seen_pg   = 1'b0;
      seen_busy = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         obs_kon[bus.slot_I] = bus.kon_I;
         seen_pg   |= bus.pg_rst_III;
         seen_busy |= bus.busy;
      end
      check("post rst kon slots", obs_kon, 32'h0000_0000);
      check("post rst pg", seen_pg, 1'b0);
      check("post rst busy", seen_busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

endmodule
